// File: rtl/power_sample_accumulator.sv
// Windowed accumulator for ADC samples: collects sum, min, max and count over a
// window, then holds the results stable and pulses done when the window closes.
module power_sample_accumulator #(
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 32,
    parameter int SUM_W    = 48
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [SAMPLE_W-1:0] s_sample,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [CNT_W-1:0]    cfg_len,
    output logic [SUM_W-1:0]    res_sum,
    output logic [SAMPLE_W-1:0] res_min,
    output logic [SAMPLE_W-1:0] res_max,
    output logic [CNT_W-1:0]    res_count,
    output logic                res_ovf,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic                ready_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                ovf_reg;
    logic [SUM_W-1:0]    sum_reg;
    logic [SAMPLE_W-1:0] min_reg;
    logic [SAMPLE_W-1:0] max_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    len_reg;

    logic                accept;
    logic [SUM_W:0]      sum_next;
    logic [CNT_W-1:0]    count_next;
    logic                window_full;

    assign accept = s_valid & ready_reg;

    // One guard bit above the accumulator detects the carry-out that forces saturation.
    assign sum_next   = {1'b0, sum_reg} + {{(SUM_W - SAMPLE_W + 1){1'b0}}, s_sample};
    assign count_next = (count_reg == {CNT_W{1'b1}}) ? count_reg
                                                     : count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    assign window_full = accept && (len_reg != '0) && (count_next == len_reg);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            sum_reg   <= '0;
            min_reg   <= '1;
            max_reg   <= '0;
            count_reg <= '0;
            len_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_start) begin
                        ovf_reg   <= 1'b0;
                        sum_reg   <= '0;
                        min_reg   <= '1;
                        max_reg   <= '0;
                        count_reg <= '0;
                        len_reg   <= cfg_len;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (sum_next[SUM_W]) begin
                            sum_reg <= '1;
                            ovf_reg <= 1'b1;
                        end else begin
                            sum_reg <= sum_next[SUM_W-1:0];
                        end
                        if (s_sample < min_reg) min_reg <= s_sample;
                        if (s_sample > max_reg) max_reg <= s_sample;
                        count_reg <= count_next;
                    end
                    // cfg_start is deliberately not looked at here: a running window ignores it.
                    if (cfg_abort || window_full) begin
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign res_ovf   = ovf_reg;
    assign res_sum   = sum_reg;
    assign res_min   = min_reg;
    assign res_max   = max_reg;
    assign res_count = count_reg;

endmodule
